// File: rtl/irq_request_latch_pkg.sv
// Shared constants, FSM state encoding and a code-to-line decode helper for irq_request_latch.
package irq_request_latch_pkg;

    localparam int NUM_IRQ = 4;
    localparam int CODE_W  = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        PEND    = 2'b01,
        SERVICE = 2'b10
    } state_t;

    function automatic logic [NUM_IRQ-1:0] code_to_onehot(input logic [CODE_W-1:0] c);
        logic [NUM_IRQ-1:0] oh;
        oh    = '0;
        oh[c] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/irq_request_latch_edge_detect.sv
// edge_detect_4: registers the raw request lines and flags their rising edges.
module edge_detect_4
    import irq_request_latch_pkg::*;
(
    input  logic               clock,
    input  logic               reset_b,
    input  logic [NUM_IRQ-1:0] req,
    output logic [NUM_IRQ-1:0] rise
);

    logic [NUM_IRQ-1:0] req_d;
    logic [NUM_IRQ-1:0] req_q;

    always_comb begin
        req_d = req;
    end

    // History clears in reset, so a line held high through reset release is seen as one edge.
    always_ff @(posedge clock) begin
        if (!reset_b) begin
            req_q <= '0;
        end else begin
            req_q <= req_d;
        end
    end

    assign rise = req & ~req_q;

endmodule

// File: rtl/irq_request_latch.sv
// Pending-request latch with IDLE/PEND/SERVICE handshake toward a priority-encoding consumer.
// Build option IRQ_LATCH_EDGE_EN: edge capture plus sticky overflow; undefined gives level capture.
//
// state   | meaning
// IDLE    | nothing enabled is pending
// PEND    | irq raised, waiting for ack
// SERVICE | consumer servicing line in code, waiting for done
module irq_request_latch
    import irq_request_latch_pkg::*;
(
    input  logic               clock,
    input  logic               reset_b,
    input  logic [3:0]         req,
    input  logic [3:0]         mask,
    output logic [3:0]         d,
    output logic               irq,
    input  logic               ack,
    input  logic [1:0]         ack_code,
    input  logic               done,
    output logic               busy,
    output logic [1:0]         code,
    output logic [3:0]         overflow,
    input  logic               ovf_clr
);

    logic [NUM_IRQ-1:0] cap_ev;
    logic [NUM_IRQ-1:0] enabled;
    logic               any_en;
    logic [NUM_IRQ-1:0] clr;

    state_t             state_d, state_q;
    logic [NUM_IRQ-1:0] pending_d, pending_q;
    logic [NUM_IRQ-1:0] overflow_d, overflow_q;
    logic [CODE_W-1:0]  code_d, code_q;
    logic               irq_d, irq_q;
    logic               busy_d, busy_q;

`ifdef IRQ_LATCH_EDGE_EN
    edge_detect_4 u_edge_detect (
        .clock   (clock),
        .reset_b (reset_b),
        .req     (req),
        .rise    (cap_ev)
    );
`else
    logic ovf_clr_unused;
    assign cap_ev         = req;
    assign ovf_clr_unused = ovf_clr;
`endif

    always_comb begin
        enabled = pending_q & mask;
        any_en  = |enabled;
        clr     = '0;
        state_d = state_q;
        code_d  = code_q;

        case (state_q)
            IDLE: begin
                if (any_en) state_d = PEND;
            end
            PEND: begin
                // ack takes priority over the enabled set draining in the same cycle
                if (ack) begin
                    state_d = SERVICE;
                    code_d  = ack_code;
                    clr     = code_to_onehot(ack_code);
                end else if (!any_en) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A fresh capture overrides a clear of the same line.
        pending_d = (pending_q & ~clr) | cap_ev;

`ifdef IRQ_LATCH_EDGE_EN
        overflow_d = (overflow_q & ~{NUM_IRQ{ovf_clr}}) | (cap_ev & pending_q);
`else
        overflow_d = '0;
`endif

        irq_d  = (state_d == PEND);
        busy_d = (state_d == SERVICE);
    end

    always_ff @(posedge clock) begin
        if (!reset_b) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            overflow_q <= '0;
            code_q     <= '0;
            irq_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            code_q     <= code_d;
            irq_q      <= irq_d;
            busy_q     <= busy_d;
        end
    end

    assign d        = pending_q & mask;
    assign irq      = irq_q;
    assign busy     = busy_q;
    assign code     = code_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_irq_request_latch.sv
// Scoreboard bench for irq_request_latch: directed scenarios plus random traffic against a per-line model.
module tb_irq_request_latch;

    logic       clock = 1'b0;
    logic       reset_b = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] mask = 4'hf;
    logic       ack = 1'b0;
    logic [1:0] ack_code = '0;
    logic       done = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [3:0] d;
    logic       irq;
    logic       busy;
    logic [1:0] code;
    logic [3:0] overflow;

    irq_request_latch dut (
        .clock    (clock),
        .reset_b  (reset_b),
        .req      (req),
        .mask     (mask),
        .d        (d),
        .irq      (irq),
        .ack      (ack),
        .ack_code (ack_code),
        .done     (done),
        .busy     (busy),
        .code     (code),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         idx;
        logic [3:0] pend;
        logic       irq;
        logic       busy;
        logic [1:0] code;
        logic [3:0] ovf;
    } exp_t;

    exp_t exp_q[$];
    int   ecnt = 0;
    int   n_checks = 0;
    int   n_fail = 0;

`ifdef IRQ_LATCH_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    // Reference: phase 0 idle, 1 waiting for ack, 2 servicing
    bit [3:0] m_pend, m_ovf, m_prev;
    int       m_phase;
    bit [1:0] m_code;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, ecnt, act, exp);
        end
    endtask

    task automatic model(input bit [3:0] r, input bit [3:0] m, input bit a, input bit [1:0] ac,
                         input bit dn, input bit oc, input bit rb);
        bit [3:0] np, no;
        bit       ev, any_en, taken;
        if (!rb) begin
            m_pend = '0; m_ovf = '0; m_prev = '0; m_phase = 0; m_code = '0;
            return;
        end
        any_en = (m_pend & m) != 4'b0;
        taken  = (m_phase == 1) && a;
        for (int i = 0; i < 4; i++) begin
            ev    = EDGE ? (r[i] && !m_prev[i]) : r[i];
            np[i] = ev || (m_pend[i] && !(taken && ac == 2'(i)));
            no[i] = EDGE ? ((ev && m_pend[i]) || (m_ovf[i] && !oc)) : 1'b0;
        end
        if (m_phase == 0 && any_en)         m_phase = 1;
        else if (m_phase == 1 && taken)     begin m_phase = 2; m_code = ac; end
        else if (m_phase == 1 && !any_en)   m_phase = 0;
        else if (m_phase == 2 && dn)        m_phase = 0;
        m_pend = np;
        m_ovf  = no;
        m_prev = r;
    endtask

    task automatic step(input bit [3:0] r, input bit [3:0] m, input bit a, input bit [1:0] ac,
                        input bit dn, input bit oc, input bit rb);
        exp_t e;
        @(posedge clock);
        #1;
        req = r; mask = m; ack = a; ack_code = ac; done = dn; ovf_clr = oc; reset_b = rb;
        model(r, m, a, ac, dn, oc, rb);
        e.idx  = ecnt + 1;
        e.pend = m_pend;
        e.irq  = (m_phase == 1);
        e.busy = (m_phase == 2);
        e.code = m_code;
        e.ovf  = m_ovf;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(4'h0, 4'hf, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    endtask

    // Monitor: each edge presents a new output set; compare against the entry for that edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            ecnt++;
            #3;
            while (exp_q.size() > 0 && exp_q[0].idx <= ecnt) begin
                e = exp_q.pop_front();
                if (e.idx < ecnt) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL stale_entry: entry %0d seen at cycle %0d", e.idx, ecnt);
                end else begin
                    check("d", d, e.pend & mask);
                    check("irq", {3'b0, irq}, {3'b0, e.irq});
                    check("busy", {3'b0, busy}, {3'b0, e.busy});
                    check("code", {2'b0, code}, {2'b0, e.code});
                    check("overflow", overflow, e.ovf);
                end
            end
        end
    end

    initial begin
        step(4'h0, 4'hf, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        step(4'h0, 4'hf, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        idle(5);
        // single pulse on line 2, ack 10, done
        step(4'h4, 4'hf, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        idle(2);
        step(4'h0, 4'hf, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1);
        idle(1);
        step(4'h0, 4'hf, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1);
        idle(1);
        // two lines, serviced highest first
        step(4'h1, 4'hf, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        step(4'h8, 4'hf, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        idle(2);
        step(4'h0, 4'hf, 1'b1, 2'd3, 1'b0, 1'b0, 1'b1);
        step(4'h0, 4'hf, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1);
        idle(2);
        step(4'h0, 4'hf, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1);
        step(4'h0, 4'hf, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1);
        idle(1);
        // masked out while pending, then re-enabled
        step(4'h2, 4'hf, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        idle(2);
        step(4'h0, 4'hd, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        step(4'h0, 4'hd, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        idle(3);
        // overflow on line 1, clear, then capture coinciding with ack 01
        step(4'h2, 4'hf, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        idle(1);
        step(4'h0, 4'hf, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
        idle(1);
        step(4'h2, 4'hf, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
        step(4'h0, 4'hf, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1);
        idle(2);
        // ack naming a non-pending line, then reset during service
        step(4'h0, 4'hf, 1'b1, 2'd3, 1'b0, 1'b0, 1'b1);
        idle(1);
        step(4'h1, 4'hf, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        idle(3);
        for (int k = 0; k < 800; k++) begin
            bit [3:0] r, m;
            r = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            if (!EDGE && $urandom_range(0, 1) == 0) r = r | 4'h1;
            m = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hf;
            step(r, m, $urandom_range(0, 2) == 0, 2'($urandom), $urandom_range(0, 2) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 40) != 0);
        end
        idle(3);
        @(posedge clock);
        @(posedge clock);
        #4;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
